// File: rtl/lsu_ctrl.sv
// Load/store unit controller: bridges the MEM stage to a handshaked data memory port,
// stalling the pipeline until ack, extending load data and flagging misalign/timeout faults.
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        mis_q;
  logic        err_q;
  logic        legal;
  logic        aligned;
  logic        ok;
  logic        timeout;
  logic [31:0] load_val;

  always_comb begin
    legal = (mem_op == 3'b000) || (mem_op == 3'b001) || (mem_op == 3'b010) ||
            (mem_op == 3'b100) || (mem_op == 3'b101);
    unique case (mem_op[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    ok = legal && aligned;
  end

  assign timeout = !dmem_ack && (cnt == 8'(MAX_WAIT - 1));

  // Lane select by the captured byte offset, then extend by the captured width code.
  always_comb begin
    logic [31:0] s;
    s = dmem_rdata >> {off_q, 3'b000};
    unique case (op_q)
      3'b000:  load_val = {{24{s[7]}}, s[7:0]};
      3'b100:  load_val = {24'b0, s[7:0]};
      3'b001:  load_val = {{16{s[15]}}, s[15:0]};
      3'b101:  load_val = {16'b0, s[15:0]};
      default: load_val = s;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    unique case (state)
      IDLE: begin
        stall = mem_en;
        if (mem_en) state_nxt = ok ? WAIT : RESP;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_ack || timeout) state_nxt = RESP;
      end
      RESP: begin
        done      = 1'b1;
        misalign  = mis_q;
        bus_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must release the pipeline even if the MEM stage keeps mem_en high.
    if (rst) stall = 1'b0;
  end

  assign dmem_req = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      we_q       <= 1'b0;
      op_q       <= 3'b000;
      off_q      <= 2'b00;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata      <= 32'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (mem_en) begin
            err_q <= 1'b0;
            if (ok) begin
              mis_q     <= 1'b0;
              cnt       <= 8'd0;
              we_q      <= mem_we;
              op_q      <= mem_op;
              off_q     <= addr[1:0];
              dmem_we   <= mem_we;
              dmem_addr <= {addr[31:2], 2'b00};
              if (mem_we) begin
                unique case (mem_op[1:0])
                  2'b00: begin
                    dmem_be    <= 4'b0001 << addr[1:0];
                    dmem_wdata <= {4{wdata[7:0]}};
                  end
                  2'b01: begin
                    dmem_be    <= 4'b0011 << addr[1:0];
                    dmem_wdata <= {2{wdata[15:0]}};
                  end
                  default: begin
                    dmem_be    <= 4'b1111;
                    dmem_wdata <= wdata;
                  end
                endcase
              end else begin
                dmem_be    <= 4'b0000;
                dmem_wdata <= 32'd0;
              end
            end else begin
              mis_q <= 1'b1;
              rdata <= 32'd0;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            rdata <= we_q ? 32'd0 : load_val;
          end else if (timeout) begin
            err_q <= 1'b1;
            rdata <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected responses; a monitor
// pops and compares on every done pulse, while a memory responder acks after a set delay.
module tb_lsu_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign, bus_err;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   mem_delay = -1;
  logic [31:0] mem_word = '0;
  int   req_age = 0;

  lsu_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_we(mem_we), .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks in the (mem_delay+1)-th request cycle; mem_delay<0 never acks.
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      dmem_ack   = (mem_delay >= 0) && (req_age == mem_delay);
      dmem_rdata = mem_word;
      req_age++;
    end else begin
      dmem_ack   = 1'b0;
      dmem_rdata = 32'hDEAD_0000;
      req_age    = 0;
    end
  end

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_done_cyc"}, 32'(cyc), 32'(mon_e.cyc));
        check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
        check({mon_e.name, "_misalign"}, {31'b0, misalign}, {31'b0, mon_e.mis});
        check({mon_e.name, "_bus_err"}, {31'b0, bus_err}, {31'b0, mon_e.err});
      end
    end
  end

  // delay: WAIT cycles without ack before the ack (-1 = never ack).
  task automatic access(input string name, input logic we, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int delay, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic hold);
    exp_t e;
    int   t;
    int   reqs;
    bit   seen;
    @(negedge clk);
    t         = cyc;
    mem_delay = delay;
    mem_word  = word;
    e.name    = name;
    e.mis     = exp_mis;
    e.err     = !exp_mis && (delay < 0);
    e.rdata   = exp_rd;
    e.cyc     = exp_mis ? t + 1 : (delay < 0 ? t + 1 + MW : t + 2 + delay);
    sb.push_back(e);
    mem_en = 1'b1;
    mem_we = we;
    mem_op = op;
    addr   = a;
    wdata  = wd;
    #1;
    check({name, "_stall_accept"}, {31'b0, stall}, 32'd1);
    reqs = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!hold) mem_en = 1'b0;
      if (dmem_req === 1'b1) begin
        reqs++;
        check({name, "_dmem_addr"}, dmem_addr, {a[31:2], 2'b00});
        check({name, "_dmem_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        check({name, "_dmem_we"}, {31'b0, dmem_we}, {31'b0, we});
        if (we) check({name, "_dmem_wdata"}, dmem_wdata, exp_wd);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        check({name, "_stall_resp"}, {31'b0, stall}, 32'd0);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_no_done: got no done in 40 cycles expected done", name);
    end
    check({name, "_req_cycles"}, 32'(reqs),
          32'(exp_mis ? 0 : (delay < 0 ? MW : delay + 1)));
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_op = 3'b000; addr = '0; wdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_req", {31'b0, dmem_req}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_dmem", {dmem_addr, dmem_wdata} ^ {dmem_be, 27'b0, dmem_we, 32'b0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //     name         we    op      addr          wdata         word          dly be       exp_wdata     exp_rdata     mis   hold
    access("ld_b",      1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0);
    access("ld_bu",     1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0);
    access("ld_b_pos",  1'b0, 3'b000, 32'h0000_1001, 32'h0,        32'h80FF_1234, 1, 4'b0000, 32'h0,        32'h0000_0012, 1'b0, 1'b0);
    access("st_h",      1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        3, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0);
    access("mis_w",     1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    access("ill_111",   1'b0, 3'b111, 32'h0000_0006, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    access("ill_011",   1'b1, 3'b011, 32'h0000_0008, 32'h1234_5678, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    access("mis_h",     1'b0, 3'b101, 32'h0000_0003, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    access("ld_w_last", 1'b0, 3'b010, 32'h0000_0020, 32'h0,        32'h1234_5678, 3, 4'b0000, 32'h0,        32'h1234_5678, 1'b0, 1'b0);
    access("timeout",   1'b0, 3'b010, 32'h0000_0024, 32'h0,        32'h0,       -1, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
    access("ld_h_hi",   1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFE, 0, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0);
    access("ld_hu_hi",  1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_7FFE, 2, 4'b0000, 32'h0,        32'h0000_8001, 1'b0, 1'b0);
    access("b2b_ld_hu", 1'b0, 3'b101, 32'h0000_0010, 32'h0,        32'h8001_7FFE, 0, 4'b0000, 32'h0,        32'h0000_7FFE, 1'b0, 1'b1);
    access("b2b_st_b",  1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0,        1, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b1);
    access("b2b_st_w",  1'b1, 3'b010, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0);
    access("ld_w_pre",  1'b0, 3'b010, 32'h0000_0018, 32'h0,        32'h5555_AAAA, 0, 4'b0000, 32'h0,        32'h5555_AAAA, 1'b0, 1'b0);

    // Reset during WAIT: request and stall drop at once, no done follows.
    @(negedge clk);
    mem_delay = -1;
    mem_en = 1'b1; mem_we = 1'b0; mem_op = 3'b010; addr = 32'h0000_0040;
    @(negedge clk);
    mem_en = 1'b0;
    check("rstw_req_before", {31'b0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstw_req", {31'b0, dmem_req}, 32'd0);
    check("rstw_stall", {31'b0, stall}, 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    access("post_rst_ld", 1'b0, 3'b010, 32'h0000_0030, 32'h0, 32'hCAFE_F00D, 0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);

    repeat (6) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
